// File: rtl/spi_reg_host.sv
// SPI register-protocol initiator: turns one parallel read/write command into a
// single CS-framed mode-0 SPI transaction and returns right-aligned read data.
module spi_reg_host #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [5:0]  cmd_addr,
  input  logic [1:0]  cmd_width,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_last;
  logic [47:0]   frame;
  logic [31:0]   rx_sh;
  logic [31:0]   rx_mask;
  logic          rw_q;

  logic [47:0]   load_frame;
  logic [5:0]    load_last;
  logic [31:0]   load_mask;

  // Build the left-aligned outgoing frame, last bit index and read mask from the command
  always_comb begin
    load_frame        = '0;
    load_frame[47:40] = {cmd_rw, 1'b0, cmd_addr};
    case (cmd_width)
      2'b00: begin
        load_mask = 32'h0000_00FF;
        load_last = cmd_rw ? 6'd15 : 6'd23;
        if (cmd_rw) load_frame[39:32] = cmd_wdata[7:0];
      end
      2'b01: begin
        load_mask = 32'h0000_FFFF;
        load_last = cmd_rw ? 6'd23 : 6'd31;
        if (cmd_rw) load_frame[39:24] = cmd_wdata[15:0];
      end
      default: begin
        load_mask = '1;
        load_last = cmd_rw ? 6'd39 : 6'd47;
        if (cmd_rw) load_frame[39:8] = cmd_wdata;
      end
    endcase
  end

  // Transaction sequencer: SETUP, per-bit LOW/HIGH phases, HOLD, then the CS-high gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      bit_last  <= '0;
      frame     <= '0;
      rx_sh     <= '0;
      rx_mask   <= '0;
      rw_q      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= S_SETUP;
            cnt       <= '0;
            bit_cnt   <= '0;
            bit_last  <= load_last;
            frame     <= load_frame;
            rx_sh     <= '0;
            rx_mask   <= load_mask;
            rw_q      <= cmd_rw;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        // The accept edge only latches the command, so SETUP runs one extra
        // count: its first cycle drops CS and presents bit 0, leaving CS low
        // for CLK_DIV cycles before the first LOW phase.
        S_SETUP: begin
          if (cnt == '0) begin
            spi_cs_n <= 1'b0;
            spi_mosi <= frame[47];
            frame    <= frame << 1;
          end
          if (cnt == CW'(CLK_DIV)) begin
            state <= S_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOW: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            state   <= S_HIGH;
            cnt     <= '0;
            spi_clk <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            spi_clk <= 1'b0;
            cnt     <= '0;
            if (!rw_q && bit_cnt >= 6'd16) rx_sh <= {rx_sh[30:0], spi_miso};
            if (bit_cnt == bit_last) begin
              state    <= S_HOLD;
              spi_mosi <= 1'b0;
            end else begin
              state    <= S_LOW;
              bit_cnt  <= bit_cnt + 6'd1;
              spi_mosi <= frame[47];
              frame    <= frame << 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            state     <= S_GAP;
            cnt       <= '0;
            spi_cs_n  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= rw_q ? '0 : (rx_sh & rx_mask);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == CW'(GAP_CYC - 1)) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_reg_host.md
Name: spi_reg_host

Overview:
- SPI initiator (master) for the peripheral-harness SPI register protocol. It is the other end of the harness's SPI register responder.
- Converts a parallel register read/write command into one framed SPI transaction and returns read data.
- Used in FPGA/bench host logic and on-chip test sequencers that drive a peripheral's 6-bit register space over uio_in[4..6] and uio_out[3].

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles. Minimum 4, because the responder double-synchronizes SCLK, CS and MOSI.
- GAP_CYC, 8: minimum clk cycles that CS stays high between transactions.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle and able to accept a command
- cmd_rw  in  1  1=write, 0=read
- cmd_addr  in  6  register address
- cmd_width  in  2  00=8b, 01=16b, 10=32b, 11 treated as 32b
- cmd_wdata  in  32  write data, right-aligned
- rsp_valid  out  1  one-cycle pulse at transaction end
- rsp_rdata  out  32  read data, right-aligned and zero-extended; 0 after writes
- busy  out  1  transaction in progress, including gap
- spi_cs_n  out  1  chip select, active-low
- spi_clk  out  1  SCLK, mode 0 (idle low)
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

Behaviour:
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, cmd_ready=1 (state IDLE), rsp_valid=0, rsp_rdata=0, busy=0. Reset mid-transaction aborts immediately: CS high next cycle, no rsp_valid.
- All outputs are registered.
- Command acceptance:
  - Accept on cmd_valid && cmd_ready; all command fields are latched at that edge.
  - cmd_ready=0 from the accept edge until IDLE is re-entered.
  - cmd_valid while not ready is ignored.
- Frame is MSB-first, one byte granularity:
  - Byte 0 = {rw, 1'b0, addr[5:0]}.
  - Write: byte 0, then N data bytes (N = 1, 2, 4 from width), most-significant byte of the width-sized value first.
  - Read: byte 0, one dummy byte (MOSI=0; responder turnaround), then N data bytes captured from MISO.
  - Bit count B = 8 + (read ? 8 : 0) + 8*N. The responder infers width from the byte count before CS rises.
- State machine:
  - IDLE: on accept, go to SETUP; spi_cs_n=0 from the next cycle.
  - SETUP: CLK_DIV cycles with CS low, SCLK low, MOSI = first bit.
  - LOW: SCLK=0 for CLK_DIV cycles. MOSI updates on the first cycle of each LOW phase, except the first bit, which was set in SETUP. After the final bit's HIGH phase, go to HOLD.
  - HIGH: SCLK=1 for CLK_DIV cycles. MISO is sampled on the last clk cycle of HIGH, only during read data bits. Then return to LOW for the next bit.
  - HOLD: SCLK=0 for CLK_DIV cycles, then CS goes high. rsp_valid pulses in the same cycle CS goes high, with rsp_rdata valid.
  - GAP: GAP_CYC cycles with CS high, busy=1, then IDLE.
- Counters:
  - Bit counter 0..B-1 (6 bits, max 48).
  - Phase counter 0..CLK_DIV-1; it wraps to 0 on each phase change.
  - Read shift register is 32b. Shift in LSB-first position, left-shifting; at completion, mask to width.
- Timing:
  - Accept-to-rsp_valid latency = 1 + CLK_DIV*(2 + 2B) cycles.
  - Example: 32b write, CLK_DIV=4 → B=40, latency 329 cycles.
- Exactly B rising SCLK edges per transaction; SCLK never toggles while CS is high.
- rsp_rdata holds its value until the next rsp_valid.

Test Plan:
- Write, width=10, addr=0x05, wdata=0xDEADBEEF, CLK_DIV=4:
  - MOSI sampled on SCLK rising = 0x85,DE,AD,BE,EF; 40 rising edges.
  - rsp_valid at accept+329; rsp_rdata=0.
- Read, width=00, addr=0x3F; responder model returns 0xA5:
  - MOSI bytes 0x3F,0x00 then 0x00; 24 edges.
  - rsp_rdata=0x000000A5; upper bits zero even if MISO is high beyond byte 2.
- Read, width=01, addr=0x10; model returns 0x1234 → rsp_rdata=0x00001234; 32 edges.
- Back-to-back: second cmd_valid held during the first transaction:
  - cmd_ready=0 until IDLE; second command accepted only after ≥GAP_CYC cycles of CS high.
  - Both transactions complete with correct data.
- Reset asserted at bit 13 of a 32b write:
  - Next cycle spi_cs_n=1, spi_clk=0, no rsp_valid, cmd_ready=1.
  - A following 8b write of 0x5A to addr 0x01 transfers correctly.
- width=11 write of 0xCAFEF00D behaves identically to width=10 (40 edges, same bytes).
